// File: rtl/alu_seq.sv
// alu_seq: handshaked registered ALU with NZCV flags and an iterative shift-add multiplier
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       ALUFlags
);
    localparam int SW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] ma, mb, acc, acc_nx, r;
    logic [SW-1:0]    sh, cnt;
    logic [WIDTH:0]   sum, dif, shl, shr;
    logic             c, v;
    assign sh     = b[SW-1:0];
    assign sum    = {1'b0, a} + {1'b0, b};
    assign dif    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign shl    = {1'b0, a} << sh;
    assign shr    = {a, 1'b0} >> sh;
    assign acc_nx = mb[0] ? acc + ma : acc;
    // single-cycle datapath; the extra bit of each shift holds the last bit shifted out
    always_comb begin
        r = control == 3'b000 ? sum[WIDTH-1:0] :
            control == 3'b001 ? dif[WIDTH-1:0] :
            control == 3'b010 ? a & b :
            control == 3'b011 ? a | b :
            control == 3'b100 ? a ^ b :
            control == 3'b101 ? shl[WIDTH-1:0] :
            control == 3'b110 ? shr[WIDTH:1] : '0;
        c = control == 3'b000 ? sum[WIDTH] :
            control == 3'b001 ? dif[WIDTH] :
            control == 3'b101 ? shl[WIDTH] :
            control == 3'b110 ? shr[0] : 1'b0;
        v = control == 3'b000 ? (a[WIDTH-1] == b[WIDTH-1]) & (r[WIDTH-1] != a[WIDTH-1]) :
            control == 3'b001 ? (a[WIDTH-1] != b[WIDTH-1]) & (r[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    end
    // handshake FSM, multiplier iteration and result/flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            ALUFlags  <= '0;
            ma        <= '0;
            mb        <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    if (MUL_EN && control == 3'b111) begin
                        ma    <= a;
                        mb    <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end else begin
                        result    <= r;
                        ALUFlags  <= {r[WIDTH-1], r == '0, c, v};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                BUSY: begin
                    acc <= acc_nx;
                    ma  <= ma << 1;
                    mb  <= mb >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == SW'(WIDTH - 1)) begin
                        result    <= acc_nx;
                        ALUFlags  <= {acc_nx[WIDTH-1], acc_nx == '0, 2'b00};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table-driven checks of alu_seq plus reset, back-pressure and no-multiplier cases
module tb_alu_seq;
    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1, nv = 1'b0, nr = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  control = '0;
    logic        in_ready, out_valid, nm_ready, nm_valid;
    logic [31:0] result, nm_result;
    logic [3:0]  flags, nm_flags;
    int          errors = 0, checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, r;
        logic [3:0]  f;
        int          lat;
    } vec_t;
    vec_t tv[$];

    alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .control(control), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ALUFlags(flags)
    );
    alu_seq #(.WIDTH(32), .MUL_EN(1'b0)) nomul (
        .clk(clk), .rst(rst), .in_valid(nv), .in_ready(nm_ready), .a(a), .b(b),
        .control(control), .out_valid(nm_valid), .out_ready(nr), .result(nm_result),
        .ALUFlags(nm_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] oa, input logic [31:0] ob,
                         input logic [31:0] er, input logic [3:0] ef, input int el);
        int lat;
        control  = op;
        a        = oa;
        b        = ob;
        in_valid = 1'b1;
        chk({nm, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, el);
        chk({nm, " result"}, result, er);
        chk({nm, " flags"}, {28'b0, flags}, {28'b0, ef});
        @(negedge clk);
        chk({nm, " idle"}, {30'b0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv.push_back('{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1});
        tv.push_back('{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1});
        tv.push_back('{3'b000, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 1});
        tv.push_back('{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 1});
        tv.push_back('{3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000, 1});
        tv.push_back('{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1});
        tv.push_back('{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1});
        tv.push_back('{3'b011, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100, 1});
        tv.push_back('{3'b100, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 4'b1000, 1});
        tv.push_back('{3'b101, 32'h80000001, 32'h00000001, 32'h00000002, 4'b0010, 1});
        tv.push_back('{3'b101, 32'h12345678, 32'h00000020, 32'h12345678, 4'b0000, 1});
        tv.push_back('{3'b101, 32'h00000003, 32'h00000021, 32'h00000006, 4'b0000, 1});
        tv.push_back('{3'b110, 32'h00000001, 32'h00000001, 32'h00000000, 4'b0110, 1});
        tv.push_back('{3'b110, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 1});
        tv.push_back('{3'b110, 32'hC0000000, 32'h0000001F, 32'h00000001, 4'b0010, 1});
        tv.push_back('{3'b111, 32'h00000007, 32'h00000009, 32'h0000003F, 4'b0000, 33});
        tv.push_back('{3'b111, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0100, 33});
        tv.push_back('{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 33});
        tv.push_back('{3'b111, 32'h00012345, 32'h00000100, 32'h01234500, 4'b0000, 33});

        repeat (2) @(negedge clk);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset result", result, 32'd0);
        chk("reset flags", {28'b0, flags}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tv[i]) do_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].r, tv[i].f, tv[i].lat);

        // asynchronous reset in the middle of a multiply discards it
        control  = 3'b111;
        a        = 32'd7;
        b        = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy in_ready", {31'b0, in_ready}, 32'd0);
        chk("busy out_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midmul out_valid", {31'b0, out_valid}, 32'd0);
        chk("midmul in_ready", {31'b0, in_ready}, 32'd1);
        chk("midmul result", result, 32'd0);
        chk("midmul flags", {28'b0, flags}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op("mul after reset", 3'b111, 32'd7, 32'd9, 32'd63, 4'b0000, 33);

        // back-pressure: result held, new request ignored until hand-off
        out_ready = 1'b0;
        control   = 3'b000;
        a         = 32'd2;
        b         = 32'd3;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 32'd10;
        b = 32'd10;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d out_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("hold%0d result", k), result, 32'd5);
            chk($sformatf("hold%0d in_ready", k), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("handoff out_valid", {31'b0, out_valid}, 32'd0);
        chk("handoff in_ready", {31'b0, in_ready}, 32'd1);
        chk("handoff result", result, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        chk("next op out_valid", {31'b0, out_valid}, 32'd1);
        chk("next op result", result, 32'd20);
        @(negedge clk);
        chk("next op idle", {30'b0, in_ready, out_valid}, 32'd2);

        // build without the multiplier: op 111 answers zero in one cycle
        control = 3'b111;
        a       = 32'd7;
        b       = 32'd9;
        nv      = 1'b1;
        chk("nomul in_ready", {31'b0, nm_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        nv = 1'b0;
        chk("nomul out_valid", {31'b0, nm_valid}, 32'd1);
        chk("nomul result", nm_result, 32'd0);
        chk("nomul flags", {28'b0, nm_flags}, 32'h4);
        @(negedge clk);
        chk("nomul idle", {30'b0, nm_ready, nm_valid}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
